fp_norm_round: RTL and testbench
================================

Name: fp_norm_round

Overview:
- Post-add normalise-and-round stage that sits directly downstream of the FP adder/subtractor mantissa datapath.
- Consumes a raw sign, biased exponent and 28-bit unnormalised mantissa carrying guard/round/sticky bits.
- Produces a packed IEEE-754 single-precision result (round-to-nearest-even).
- 3-stage pipeline with valid/ready flow control; the result feeds the unit's output register or writeback.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, fraction field width
- MANT_W, 28, raw mantissa width: carry + hidden + FRAC_W + guard/round/sticky

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  synchronous reset, active-high (asserted = 1)
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept an input beat
- sign_in  in  1  result sign from the sign stage
- exp_in  in  8  biased exponent of the larger operand; 0 is treated as 1
- mant_in  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
- special_in  in  1  upstream detected NaN/Inf; bypass arithmetic
- special_val  in  32  packed word emitted when special_in = 1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  32  packed {sign, exponent, fraction}
- flags  out  3  {overflow, underflow, inexact}

Behaviour:
- Reset (rstn = 1 at a clock edge):
  - All valid bits clear: out_valid = 0, result = 0, flags = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards every in-flight beat, with no output produced for them.
- Flow control:
  - A beat transfers in when in_valid and in_ready are both 1.
  - stall = out_valid & ~out_ready. All stages hold when stall is 1.
  - in_ready = ~stall. No bubble collapsing.
- Latency is exactly 3 cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle.
- result, flags and out_valid stay stable while stalled. Beat order is preserved. No beat is lost or duplicated.
- S1, detect and count:
  - If mant_in[27] = 1: right-shift by 1, OR the shifted-out bit into sticky, exp + 1.
  - Else: lz = leading-zero count of mant_in[26:0] (0..27).
  - Register mant, exp, lz, sign, special.
- S2, normalise:
  - shift = min(lz, exp − 1); mant <<= shift; exp −= shift.
  - If the hidden bit is still 0 after the shift, the result is subnormal and the exponent field is forced to 0.
  - If mant == 0 (exact cancellation), mark zero.
- S3, round and pack:
  - RNE: lsb = mant[3], g = mant[2], r|s = mant[1] | mant[0]. Round up iff g & (r | s | lsb).
  - A carry into bit 27 after increment renormalises: frac = 0, exp + 1. A subnormal rounding into bit 26 becomes exp = 1.
  - exp ≥ 255 after rounding: result = {sign, 8'hFF, 0}, overflow = 1, inexact = 1.
  - Zero: result = 32'h0000_0000 (+0 under RNE cancellation), flags = 0.
  - underflow = subnormal & inexact. inexact = g | r | s before rounding.
  - special_in: result = special_val, flags = 0; carried through all three stages unchanged.
- Simultaneous events:
  - stall asserted while in_valid = 1: the input is not accepted, and the upstream holds it.
  - out_ready returning high releases all stages on the same edge.

Decomposition:
- Shared package fp_pkg:
  - Constants: EXP_BIAS = 127, EXP_MAX = 8'hFF, QNAN = 32'h7FC0_0000.
  - typedef fp32_t: packed struct {sign, exp[7:0], frac[22:0]}.
  - typedef norm_in_t: bundle of sign, exp, mant, special.
- One sub-module: fp_lzc27, a combinational leading-zero counter, 27-bit input, 5-bit count, output 27 when the input is all zero.

Test Plan:
- 1.0 + 1.0: exp_in = 127, mant_in = 28'h800_0000, out_ready = 1 → result 32'h4000_0000 exactly 3 cycles later, flags 0.
- Tie to even: exp_in = 127, mant_in = hidden | frac lsb (bit 3) | guard (bit 2) → result 32'h3F80_0002, inexact = 1. The same input with frac lsb = 0 → 32'h3F80_0000.
- Cancellation and overflow:
  - mant_in = 0 → result 32'h0000_0000.
  - exp_in = 254, mant_in = 28'h800_0000 → result {sign, 8'hFF, 0} with overflow = 1.
- Subnormal: exp_in = 1, mant_in = 28'h200_0000 (bit 25) → exponent field 0, result 32'h0040_0000, underflow = 0 (exact).
- Backpressure: 6 back-to-back beats with out_ready held 0 for cycles 4–9 → in_ready falls when stall begins; all 6 results appear in order, each held stable while stalled; none lost.
- Reset mid-flight: assert rstn with 3 beats in flight → out_valid = 0 the next cycle and none of the 3 results ever appear. A special_in beat with special_val = 32'h7FC0_0000 emits 7FC0_0000 with flags 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision normalise/round datapath.
package fp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // Internal exponent width: headroom for carry-out and rounding past 255.
  localparam int unsigned EXPI_W = 10;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic        overflow;
    logic        underflow;
    logic        inexact;
  } flags_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic        special;
  } norm_in_t;

  // After detect/count: carry already folded in, bit 26 is the hidden position.
  typedef struct packed {
    logic              sign;
    logic [EXPI_W-1:0] exp;
    logic [26:0]       mant;
    logic [4:0]        lz;
    logic              special;
    logic [31:0]       special_val;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic [EXPI_W-1:0] exp;
    logic [26:0]       mant;
    logic              subnormal;
    logic              zero;
    logic              special;
    logic [31:0]       special_val;
  } s2_t;

  function automatic fp32_t pack_inf(input logic sign);
    return '{sign: sign, exp: EXP_MAX, frac: '0};
  endfunction

endpackage

// File: rtl/fp_lzc27.sv
// Leading-zero counter over a 27-bit mantissa; reports 27 for an all-zero input.
module fp_lzc27 (
  input  logic [26:0] i_vec,
  output logic [4:0]  o_cnt
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_vec[i]) o_cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalise and round-to-nearest-even stage, 3-deep pipeline with valid/ready.
module fp_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int MANT_W = 28
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [MANT_W-1:0]       mant_in,
  input  logic                    special_in,
  input  logic [EXP_W+FRAC_W:0]   special_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [2:0]              flags
);

  import fp_pkg::*;

  logic     w_stall;
  norm_in_t w_in;

  logic     r_v1;
  logic     r_v2;
  logic     r_out_valid;
  fp32_t    r_result;
  flags_t   r_flags;

  assign w_stall  = r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  assign w_in = '{sign: sign_in, exp: exp_in, mant: mant_in, special: special_in};

  // ---------------- S1: fold carry, count leading zeros ----------------
  logic [4:0] w_lz;
  s1_t        w_s1;
  s1_t        r_s1;

  fp_lzc27 u_lzc (
    .i_vec (w_in.mant[26:0]),
    .o_cnt (w_lz)
  );

  always_comb begin
    w_s1.sign        = w_in.sign;
    w_s1.special     = w_in.special;
    w_s1.special_val = special_val;
    w_s1.exp         = (w_in.exp == '0) ? EXPI_W'(1) : EXPI_W'(w_in.exp);
    if (w_in.mant[27]) begin
      // Shifted-out bit must survive as sticky so rounding still sees it.
      w_s1.mant = {w_in.mant[27:2], w_in.mant[1] | w_in.mant[0]};
      w_s1.exp  = w_s1.exp + EXPI_W'(1);
      w_s1.lz   = '0;
    end else begin
      w_s1.mant = w_in.mant[26:0];
      w_s1.lz   = w_lz;
    end
  end

  // ---------------- S2: normalise, clamped at the minimum exponent ----------------
  logic [EXPI_W-1:0] w_exp_m1;
  logic [4:0]        w_shift;
  s2_t               w_s2;
  s2_t               r_s2;

  always_comb begin
    w_exp_m1 = r_s1.exp - EXPI_W'(1);
    w_shift  = (EXPI_W'(r_s1.lz) < w_exp_m1) ? r_s1.lz : w_exp_m1[4:0];

    w_s2.sign        = r_s1.sign;
    w_s2.special     = r_s1.special;
    w_s2.special_val = r_s1.special_val;
    w_s2.mant        = r_s1.mant << w_shift;
    w_s2.exp         = r_s1.exp - EXPI_W'(w_shift);
    w_s2.zero        = (r_s1.mant == '0);
    w_s2.subnormal   = ~w_s2.mant[26] & ~w_s2.zero;
  end

  // ---------------- S3: round to nearest even and pack ----------------
  logic              w_lsb;
  logic              w_g;
  logic              w_rs;
  logic              w_up;
  logic              w_inexact;
  logic              w_ovf;
  logic [24:0]       w_sum;
  logic [EXPI_W-1:0] w_exp_fin;
  fp32_t             w_res;
  flags_t            w_flags;

  always_comb begin
    w_lsb     = r_s2.mant[3];
    w_g       = r_s2.mant[2];
    w_rs      = r_s2.mant[1] | r_s2.mant[0];
    w_up      = w_g & (w_rs | w_lsb);
    w_inexact = w_g | w_rs;
    w_sum     = {1'b0, r_s2.mant[26:3]} + 25'(w_up);

    // A subnormal that rounds into the hidden bit becomes the smallest normal.
    w_exp_fin = r_s2.subnormal ? EXPI_W'(w_sum[23])
                               : r_s2.exp + EXPI_W'(w_sum[24]);
    w_ovf     = (w_exp_fin >= EXPI_W'(EXP_MAX));

    w_res   = '{sign: r_s2.sign, exp: w_exp_fin[7:0], frac: w_sum[22:0]};
    w_flags = '{overflow:  1'b0,
                underflow: r_s2.subnormal & w_inexact,
                inexact:   w_inexact};

    if (r_s2.special) begin
      w_res   = r_s2.special_val;
      w_flags = '0;
    end else if (r_s2.zero) begin
      w_res   = '0;
      w_flags = '0;
    end else if (w_ovf) begin
      w_res   = pack_inf(r_s2.sign);
      w_flags = '{overflow: 1'b1, underflow: 1'b0, inexact: 1'b1};
    end
  end

  // ---------------- pipeline registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (!w_stall) begin
      r_v1        <= in_valid;
      r_v2        <= r_v1;
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

  // NOTE: datapath payload is left unreset; the valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s1 <= w_s1;
      r_s2 <= w_s2;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed vectors, flow-control sequences, random vs. model.
module tb_fp_norm_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mant_in;
  logic        special_in;
  logic [31:0] special_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_norm_round dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign_in     (sign_in),
    .exp_in      (exp_in),
    .mant_in     (mant_in),
    .special_in  (special_in),
    .special_val (special_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic        special;
    logic [31:0] sval;
    logic [31:0] exp_res;
    logic [2:0]  exp_flags;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  vec_t vq[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string n, input logic s, input logic [7:0] e, input logic [27:0] m,
                         input logic sp, input logic [31:0] sv, input logic [31:0] r, input logic [2:0] f);
    vec_t v;
    v.name = n; v.sign = s; v.exp = e; v.mant = m; v.special = sp; v.sval = sv;
    v.exp_res = r; v.exp_flags = f;
    vq.push_back(v);
  endtask

  task automatic drive_beat(input logic s, input logic [7:0] e, input logic [27:0] m,
                            input logic sp, input logic [31:0] sv);
    sign_in = s; exp_in = e; mant_in = m; special_in = sp; special_val = sv;
  endtask

  // Reference: treat mant as an exact integer scaled by 2^(e-153), pick the rounding
  // granularity k (24 significant bits, never finer than the subnormal ulp), round RNE.
  function automatic exp_t ref_model(input logic s, input logic [7:0] e_in, input logic [27:0] m_in,
                                     input logic sp, input logic [31:0] spv);
    exp_t   o;
    longint m, e, p, k, q, rem, half, word;
    bit     inexact, sub;
    if (sp) begin
      o.res = spv; o.fl = 3'b000;
      return o;
    end
    if (m_in == 28'd0) begin
      o.res = 32'h0; o.fl = 3'b000;
      return o;
    end
    m = longint'(m_in);
    e = (e_in == 8'd0) ? 64'd1 : longint'(e_in);
    p = 0;
    for (int i = 0; i < 28; i++) if (m_in[i]) p = i;
    k = (p - 23 > 4 - e) ? p - 23 : 4 - e;
    sub = (e + p - 26) < 1;
    if (k <= 0) begin
      q = m << (-k);
      inexact = 1'b0;
    end else begin
      q = m >> k;
      rem = m & ((longint'(1) << k) - 1);
      half = longint'(1) << (k - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    word = ((k + e - 4) << 23) + q;
    if (word >= 64'h7F80_0000) begin
      o.res = {s, 31'h7F80_0000}; o.fl = 3'b101;
    end else begin
      o.res = {s, word[30:0]}; o.fl = {1'b0, sub & inexact, inexact};
    end
    return o;
  endfunction

  task automatic run_vec(input vec_t v);
    check({v.name, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    drive_beat(v.sign, v.exp, v.mant, v.special, v.sval);
    tick();
    in_valid = 1'b0;
    tick();
    check({v.name, "/early"}, 32'(out_valid), 32'd0);
    tick();
    check({v.name, "/valid"}, 32'(out_valid), 32'd1);
    check({v.name, "/result"}, result, v.exp_res);
    check({v.name, "/flags"}, 32'(flags), 32'(v.exp_flags));
    tick();
  endtask

  initial begin
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive_beat(1'b0, 8'd0, 28'd0, 1'b0, 32'd0);
    tick(); tick();
    rstn = 1'b0;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/flags", 32'(flags), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);

    // ---------------- directed vectors ----------------
    add_vec("one_plus_one",   1'b0, 8'd127, 28'h800_0000, 1'b0, 32'd0, 32'h4000_0000, 3'b000);
    add_vec("tie_odd_up",     1'b0, 8'd127, 28'h400_000C, 1'b0, 32'd0, 32'h3F80_0002, 3'b001);
    add_vec("tie_even_stay",  1'b0, 8'd127, 28'h400_0004, 1'b0, 32'd0, 32'h3F80_0000, 3'b001);
    add_vec("cancel_zero",    1'b1, 8'd100, 28'h000_0000, 1'b0, 32'd0, 32'h0000_0000, 3'b000);
    add_vec("overflow_pos",   1'b0, 8'd254, 28'h800_0000, 1'b0, 32'd0, 32'h7F80_0000, 3'b101);
    add_vec("overflow_neg",   1'b1, 8'd254, 28'h800_0000, 1'b0, 32'd0, 32'hFF80_0000, 3'b101);
    add_vec("overflow_e255",  1'b0, 8'd255, 28'h400_0000, 1'b0, 32'd0, 32'h7F80_0000, 3'b101);
    add_vec("subnorm_exact",  1'b0, 8'd1,   28'h200_0000, 1'b0, 32'd0, 32'h0040_0000, 3'b000);
    add_vec("exp0_as_1",      1'b0, 8'd0,   28'h000_0008, 1'b0, 32'd0, 32'h0000_0001, 3'b000);
    add_vec("subnorm_uflow",  1'b0, 8'd1,   28'h000_000C, 1'b0, 32'd0, 32'h0000_0002, 3'b011);
    add_vec("subnorm_to_min", 1'b0, 8'd1,   28'h3FF_FFFC, 1'b0, 32'd0, 32'h0080_0000, 3'b011);
    add_vec("round_carry",    1'b0, 8'd127, 28'h7FF_FFFC, 1'b0, 32'd0, 32'h4000_0000, 3'b001);
    add_vec("carry_sticky",   1'b0, 8'd127, 28'h800_000C, 1'b0, 32'd0, 32'h4000_0001, 3'b001);
    add_vec("left_shift",     1'b0, 8'd130, 28'h040_0000, 1'b0, 32'd0, 32'h3F00_0000, 3'b000);
    add_vec("clamp_shift",    1'b0, 8'd20,  28'h000_0010, 1'b0, 32'd0, 32'h0010_0000, 3'b000);
    add_vec("neg_one",        1'b1, 8'd127, 28'h400_0000, 1'b0, 32'd0, 32'hBF80_0000, 3'b000);
    add_vec("special_qnan",   1'b0, 8'd127, 28'h800_000F, 1'b1, QNAN,  32'h7FC0_0000, 3'b000);
    foreach (vq[i]) run_vec(vq[i]);

    // ---------------- backpressure: 6 beats, out_ready low in cycles 4..9 ----------------
    begin
      int idx = 0, got = 0;
      logic prev_stall = 1'b0;
      logic [31:0] prev_res = '0;
      logic [2:0]  prev_fl = '0;
      sb.delete();
      for (int c = 0; c < 40; c++) begin
        out_ready = !(c >= 4 && c <= 9);
        in_valid  = (idx < 6);
        drive_beat(1'(idx & 1), 8'(100 + 10 * idx), 28'h400_0000 | 28'(idx * 37), 1'b0, 32'd0);
        #1;
        if (c == 3) check("bp/ready_before", 32'(in_ready), 32'd1);
        if (c == 4) check("bp/ready_stall", 32'(in_ready), 32'd0);
        if (prev_stall) begin
          check("bp/hold_valid", 32'(out_valid), 32'd1);
          check("bp/hold_result", result, prev_res);
          check("bp/hold_flags", 32'(flags), 32'(prev_fl));
        end
        if (out_valid && out_ready) begin
          exp_t x;
          if (sb.size() == 0) check("bp/unexpected", 32'd1, 32'd0);
          else begin
            x = sb.pop_front();
            check("bp/result", result, x.res);
            check("bp/flags", 32'(flags), 32'(x.fl));
          end
          got++;
        end
        prev_stall = out_valid & ~out_ready;
        prev_res = result;
        prev_fl = flags;
        if (in_valid && in_ready) begin
          sb.push_back(ref_model(sign_in, exp_in, mant_in, special_in, special_val));
          idx++;
        end
        tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("bp/count", got, 32'd6);
    end

    // ---------------- reset with three beats in flight ----------------
    begin
      logic seen = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
        in_valid = 1'b1;
        drive_beat(1'b0, 8'd127, 28'h400_0000 | (28'(c + 1) << 10), 1'b0, 32'd0);
        rstn = (c == 2);
        tick();
      end
      rstn = 1'b0;
      in_valid = 1'b0;
      check("rst/out_valid", 32'(out_valid), 32'd0);
      check("rst/in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 12; c++) begin
        if (out_valid) seen = 1'b1;
        tick();
      end
      check("rst/no_ghost", 32'(seen), 32'd0);
      run_vec(vq[vq.size() - 1]);
    end

    // ---------------- random stream vs. reference model ----------------
    begin
      int sent = 0, cyc = 0;
      bit pend = 1'b0;
      logic prev_stall = 1'b0;
      logic [31:0] prev_res = '0;
      logic [2:0]  prev_fl = '0;
      logic [27:0] m;
      sb.delete();
      while ((sent < 3000 || sb.size() != 0) && cyc < 40000) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (!pend && sent < 3000 && $urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 4))
            0:       m = 28'($urandom);
            1:       m = 28'($urandom) >> $urandom_range(0, 27);
            2:       m = {2'b01, 26'($urandom)};
            3:       m = (28'($urandom) & 28'hFFF_FFF8) | 28'h4;
            default: m = ($urandom_range(0, 3) == 0) ? 28'd0 : 28'($urandom_range(0, 255));
          endcase
          case ($urandom_range(0, 3))
            0:       exp_in = 8'($urandom_range(0, 8));
            1:       exp_in = 8'($urandom_range(245, 255));
            default: exp_in = 8'($urandom_range(0, 255));
          endcase
          sign_in = 1'($urandom_range(0, 1));
          mant_in = m;
          special_in = ($urandom_range(0, 19) == 0);
          special_val = $urandom;
          pend = 1'b1;
        end
        in_valid = pend;
        #1;
        if (prev_stall) begin
          check("rand/hold_valid", 32'(out_valid), 32'd1);
          check("rand/hold_result", result, prev_res);
          check("rand/hold_flags", 32'(flags), 32'(prev_fl));
        end
        if (out_valid && out_ready) begin
          exp_t x;
          if (sb.size() == 0) check("rand/unexpected", 32'd1, 32'd0);
          else begin
            x = sb.pop_front();
            check("rand/result", result, x.res);
            check("rand/flags", 32'(flags), 32'(x.fl));
          end
        end
        prev_stall = out_valid & ~out_ready;
        prev_res = result;
        prev_fl = flags;
        if (in_valid && in_ready) begin
          sb.push_back(ref_model(sign_in, exp_in, mant_in, special_in, special_val));
          pend = 1'b0;
          sent++;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      check("rand/sent", sent, 32'd3000);
      check("rand/drained", sb.size(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
